// File: rtl/register_file.sv
// Integer register file x0..x31: two enable-gated combinational read channels,
// one synchronous write port, and a registered debug read port.
module register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              register_rd_ch0_en,
  input  logic [ADDR_W-1:0] register_rd_ch0_addr,
  output logic [DATA_W-1:0] register_rd_ch0_data,
  input  logic              register_rd_ch1_en,
  input  logic [ADDR_W-1:0] register_rd_ch1_addr,
  output logic [DATA_W-1:0] register_rd_ch1_data,
  input  logic              register_wr_en,
  input  logic [ADDR_W-1:0] register_wr_addr,
  input  logic [DATA_W-1:0] register_wr_data,
  input  logic              dbg_rd_en,
  input  logic [ADDR_W-1:0] dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              dbg_rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // x0 has no storage; the array starts at entry 1.
  logic [DATA_W-1:0] mem_q [1:DEPTH-1];
  logic [DATA_W-1:0] mem_d [1:DEPTH-1];
  logic [DATA_W-1:0] dbg_rd_data_q, dbg_rd_data_d;
  logic              dbg_rd_valid_q, dbg_rd_valid_d;

  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    if (a == '0) rd_word = '0;
    else         rd_word = mem_q[a];
  endfunction

  // Read channels are forced to zero when disabled so the bypass logic can OR them in.
  assign register_rd_ch0_data = register_rd_ch0_en ? rd_word(register_rd_ch0_addr) : '0;
  assign register_rd_ch1_data = register_rd_ch1_en ? rd_word(register_rd_ch1_addr) : '0;

  always_comb begin
    mem_d          = mem_q;
    dbg_rd_data_d  = dbg_rd_data_q;
    dbg_rd_valid_d = 1'b0;
    if (register_wr_en && (register_wr_addr != '0)) begin
      mem_d[register_wr_addr] = register_wr_data;
    end
    if (dbg_rd_en) begin
      dbg_rd_data_d  = rd_word(dbg_rd_addr);
      dbg_rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q          <= '{default: '0};
      dbg_rd_data_q  <= '0;
      dbg_rd_valid_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      dbg_rd_data_q  <= dbg_rd_data_d;
      dbg_rd_valid_q <= dbg_rd_valid_d;
    end
  end

  assign dbg_rd_data  = dbg_rd_data_q;
  assign dbg_rd_valid = dbg_rd_valid_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by a
// randomized run, compared every cycle against an array reference model.
module tb_register_file;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              ch0_en, ch1_en, wr_en, dbg_en;
  logic [ADDR_W-1:0] ch0_addr, ch1_addr, wr_addr, dbg_addr;
  logic [DATA_W-1:0] ch0_data, ch1_data, wr_data, dbg_data;
  logic              dbg_valid;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference state: architectural register values plus expected debug outputs.
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_dbg_data;
  logic              exp_dbg_valid;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .register_rd_ch0_en   (ch0_en),
    .register_rd_ch0_addr (ch0_addr),
    .register_rd_ch0_data (ch0_data),
    .register_rd_ch1_en   (ch1_en),
    .register_rd_ch1_addr (ch1_addr),
    .register_rd_ch1_data (ch1_data),
    .register_wr_en       (wr_en),
    .register_wr_addr     (wr_addr),
    .register_wr_data     (wr_data),
    .dbg_rd_en            (dbg_en),
    .dbg_rd_addr          (dbg_addr),
    .dbg_rd_data          (dbg_data),
    .dbg_rd_valid         (dbg_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_rd(input logic en, input logic [ADDR_W-1:0] a);
    return (en && a != '0) ? model_mem[a] : '0;
  endfunction

  task automatic idle_inputs();
    reset_n = 1'b1;
    ch0_en = 1'b0; ch0_addr = '0;
    ch1_en = 1'b0; ch1_addr = '0;
    wr_en  = 1'b0; wr_addr  = '0; wr_data = '0;
    dbg_en = 1'b0; dbg_addr = '0;
  endtask

  // One clock: check combinational reads, advance the model at the edge, check debug outputs.
  task automatic cycle();
    #1;
    chk("ch0_data", ch0_data, model_rd(ch0_en, ch0_addr));
    chk("ch1_data", ch1_data, model_rd(ch1_en, ch1_addr));
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      exp_dbg_data  = '0;
      exp_dbg_valid = 1'b0;
    end else begin
      if (dbg_en) exp_dbg_data = (dbg_addr == '0) ? '0 : model_mem[dbg_addr];
      exp_dbg_valid = dbg_en;
      if (wr_en && wr_addr != '0) model_mem[wr_addr] = wr_data;
    end
    #1;
    chk("dbg_rd_data", dbg_data, exp_dbg_data);
    chk("dbg_rd_valid", DATA_W'(dbg_valid), DATA_W'(exp_dbg_valid));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_dbg_data  = '0;
    exp_dbg_valid = 1'b0;
    idle_inputs();

    // Reset and check reset state.
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("reset_dbg_data_zero", dbg_data, 32'h0);

    // x5 write, then read on ch0 with ch1 disabled.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    ch0_en = 1'b1; ch0_addr = 5'd5; ch1_en = 1'b0; ch1_addr = 5'd5;
    #1;
    chk("x5_ch0", ch0_data, 32'hDEADBEEF);
    chk("x5_ch1_disabled", ch1_data, 32'h0);
    cycle();

    // Write to x0 is dropped; all ports read 0.
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    cycle();
    idle_inputs();
    ch0_en = 1'b1; ch1_en = 1'b1; dbg_en = 1'b1;
    #1;
    chk("x0_ch0", ch0_data, 32'h0);
    chk("x0_ch1", ch1_data, 32'h0);
    cycle();
    chk("x0_dbg", dbg_data, 32'h0);
    chk("x0_dbg_valid", DATA_W'(dbg_valid), 32'h1);
    idle_inputs();
    cycle();
    chk("x0_dbg_valid_drop", DATA_W'(dbg_valid), 32'h0);

    // No write-to-read forwarding on x7.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;
    cycle();
    wr_data = 32'h22222222; ch0_en = 1'b1; ch0_addr = 5'd7;
    #1;
    chk("x7_prewrite", ch0_data, 32'h11111111);
    cycle();
    wr_en = 1'b0;
    #1;
    chk("x7_postwrite", ch0_data, 32'h22222222);
    cycle();

    // Fill x1..x31 and sweep them back-to-back on the debug port.
    idle_inputs();
    for (int i = 1; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 32'(i) * 32'h01010101;
      cycle();
    end
    wr_en = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      dbg_en = 1'b1; dbg_addr = ADDR_W'(i);
      ch1_en = 1'b1; ch1_addr = ADDR_W'(DEPTH - i);
      cycle();
      chk("sweep_dbg_data", dbg_data, 32'(i) * 32'h01010101);
      chk("sweep_dbg_valid", DATA_W'(dbg_valid), 32'h1);
    end
    idle_inputs();
    cycle();
    chk("sweep_hold_data", dbg_data, 32'h1F1F1F1F);

    // Reset cycle swallows a write and a debug request.
    reset_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    dbg_en = 1'b1; dbg_addr = 5'd3;
    cycle();
    chk("rst_dbg_valid", DATA_W'(dbg_valid), 32'h0);
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      ch0_en = 1'b1; ch0_addr = ADDR_W'(i);
      ch1_en = 1'b1; ch1_addr = ADDR_W'(DEPTH - 1 - i);
      #1;
      chk("rst_entry_zero", ch0_data, 32'h0);
      cycle();
    end

    // Randomized run against the reference model.
    for (int c = 0; c < 10000; c++) begin
      reset_n  = ($urandom_range(0, 499) != 0);
      ch0_en   = 1'($urandom);
      ch0_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      ch1_en   = 1'($urandom);
      ch1_addr = ($urandom_range(0, 3) == 0) ? ch0_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = ($urandom_range(0, 3) == 0) ? ch0_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_data  = $urandom;
      dbg_en   = 1'($urandom);
      dbg_addr = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Integer register file (x0–x31) for the in-order pipeline. It is the responder behind the ID-stage bypass logic: it serves two enable-gated combinational read channels and takes one synchronous write port from the WB stage. Read data is forced to zero when a channel is not enabled, so the bypass logic can OR it with its forwarded values. A registered debug read port gives trace and test access without disturbing the pipeline ports.

## Interface
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2^ADDR_W entries, and entry 0 is x0.
- clk  input  1  core clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- register_rd_ch0_en  input  1  read enable, channel 0 (rs1).
- register_rd_ch0_addr  input  ADDR_W  read address, channel 0.
- register_rd_ch0_data  output  DATA_W  read data, channel 0; zero when the channel is not enabled.
- register_rd_ch1_en  input  1  read enable, channel 1 (rs2).
- register_rd_ch1_addr  input  ADDR_W  read address, channel 1.
- register_rd_ch1_data  output  DATA_W  read data, channel 1; zero when the channel is not enabled.
- register_wr_en  input  1  write enable from the WB stage (wb_dest_valid).
- register_wr_addr  input  ADDR_W  write address (wb_dest_addr).
- register_wr_data  input  DATA_W  write data (wb_dest_data).
- dbg_rd_en  input  1  debug read request.
- dbg_rd_addr  input  ADDR_W  debug read address.
- dbg_rd_data  output  DATA_W  registered debug read data.
- dbg_rd_valid  output  1  one-cycle pulse marking dbg_rd_data valid.

## Operation
- Storage: entries 1 .. 2^ADDR_W-1 are flops. x0 has no storage and always reads as 0.
- Write: on a rising edge with reset_n=1, register_wr_en=1 and register_wr_addr!=0, the entry at register_wr_addr takes register_wr_data.
  - Writes to x0 are dropped silently.
- Read channels (ch0 and ch1 identical, fully combinational):
  - data = (en & addr!=0) ? mem[addr] : 0.
  - en=0 must give exactly 0, never stale data, because the consumer ORs this output with its bypass terms.
- Both channels may read the same address in the same cycle; both return the same value.
- There is no internal write-to-read forwarding.
  - A same-cycle read of the address being written returns the pre-write value.
  - The WB bypass path upstream covers this case.
- Debug port:
  - When dbg_rd_en=1, dbg_rd_data <= (dbg_rd_addr==0) ? 0 : mem[dbg_rd_addr] at the next edge, and dbg_rd_valid <= 1.
  - When dbg_rd_en=0, dbg_rd_valid <= 0 and dbg_rd_data holds its last value.
  - The debug read samples the pre-write value when a write to the same address happens in the same cycle.
- Reset (reset_n=0 at a rising edge):
  - All entries clear to 0; dbg_rd_data <= 0; dbg_rd_valid <= 0.
  - Any write or debug request presented in that cycle is ignored.

## Timing
- Read channels: zero latency, combinational from en/addr and the current array contents.
- Write: takes effect at the rising edge; visible on the read channels from the next cycle onward.
- Debug read: 1-cycle latency with back-to-back support; a request every cycle gives a valid result every cycle.
- Reset values: all entries 0, dbg_rd_data=0, dbg_rd_valid=0.
  - The read channel outputs follow array contents and become 0 from the first cycle after the reset edge.
- Reset mid-operation: a write in the reset cycle is lost, and a debug request in the reset cycle produces no valid pulse.
- Boundaries:
  - Address 2^ADDR_W-1 (x31) behaves like any other entry.
  - Address 0 on any port returns 0.
  - A write to x0 followed by a read of x0 returns 0.

## Test plan
- Write x5=0xDEADBEEF, then the next cycle set ch0 en=1, addr=5 -> register_rd_ch0_data=0xDEADBEEF; ch1 en=0 -> register_rd_ch1_data=0x00000000.
- Write x0=0xFFFFFFFF, then read x0 on ch0, ch1 and the debug port -> all return 0; dbg_rd_valid pulses for 1 cycle.
- Preload x7=0x11111111. In one cycle, write x7=0x22222222 and read x7 on ch0 -> 0x11111111 that cycle, 0x22222222 the next cycle.
- Fill x1..x31 with value=addr*0x01010101, then run a 31-cycle back-to-back debug sweep -> each result appears one cycle after its request with the matching value; dbg_rd_valid stays high for 31 cycles.
- Hold reset_n=0 for 1 cycle while writing x3=0xA5A5A5A5 with dbg_rd_en=1 -> x3 reads 0 afterward, all entries read 0, and dbg_rd_valid stays 0.
- Run 10k cycles of random reads, writes and debug requests against a reference array model -> exact match on all outputs every cycle; read outputs are 0 whenever en=0.
